// File: rtl/matmul_pkg.sv
// Shared types and width helpers for the sequential matrix multiplier.
// Signed arithmetic is enabled by defining MATMUL_SIGNED_EN.
package matmul_pkg;

    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

    // Holds a sum of n products of two dw-bit operands without overflow
    function automatic int unsigned calc_aw(input int unsigned dw, input int unsigned n);
        return 2 * dw + $clog2(n);
    endfunction

    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/matmul_mac_unit.sv
// Combinational multiply-accumulate: sum = acc_in + a*b, computed at AW bits.
// Operands are sign- or zero-extended according to signed_mode.
module matmul_mac_unit #(
    parameter int unsigned DW = 4,
    parameter int unsigned AW = 9
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [AW-1:0] acc_in,
    input  logic          signed_mode,
    output logic [AW-1:0] sum
);

    logic [AW-1:0] a_ext;
    logic [AW-1:0] b_ext;
    logic [AW-1:0] prod;

    // The exact result fits in AW bits, so the truncated two's-complement product is exact
    always_comb begin
        a_ext = signed_mode ? {{(AW-DW){a[DW-1]}}, a} : {{(AW-DW){1'b0}}, a};
        b_ext = signed_mode ? {{(AW-DW){b[DW-1]}}, b} : {{(AW-DW){1'b0}}, b};
        prod  = a_ext * b_ext;
        sum   = acc_in + prod;
    end

endmodule

// File: rtl/param_matrix_multiplier.sv
// Sequential NxN matrix multiplier with one shared MAC, double-buffered result and
// a completed-matrix counter. Define MATMUL_SIGNED_EN for two's-complement elements.
module param_matrix_multiplier
    import matmul_pkg::*;
#(
    parameter  int unsigned N  = 2,
    parameter  int unsigned DW = 4,
    parameter  int unsigned CW = 8,
    localparam int unsigned AW = calc_aw(DW, N)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [N*N*DW-1:0] matrix_A,
    input  logic [N*N*DW-1:0] matrix_B,
    output logic              busy,
    output logic              done,
    output logic [N*N*AW-1:0] matrix_result,
    output logic [CW-1:0]     matrix_count
);

    localparam int unsigned IW = idx_w(N);
`ifdef MATMUL_SIGNED_EN
    localparam logic SIGNED_MODE = 1'b1;
`else
    localparam logic SIGNED_MODE = 1'b0;
`endif

    state_t            state;
    logic [N*N*DW-1:0] a_reg;
    logic [N*N*DW-1:0] b_reg;
    logic [N*N*AW-1:0] work;
    logic [AW-1:0]     acc;
    logic [AW-1:0]     sum;
    logic [IW-1:0]     i;
    logic [IW-1:0]     j;
    logic [IW-1:0]     k;
    logic [DW-1:0]     a_el;
    logic [DW-1:0]     b_el;

    always_comb begin
        a_el = a_reg[(int'(i) * N + int'(k)) * DW +: DW];
        b_el = b_reg[(int'(k) * N + int'(j)) * DW +: DW];
    end

    matmul_mac_unit #(
        .DW (DW),
        .AW (AW)
    ) u_mac (
        .a           (a_el),
        .b           (b_el),
        .acc_in      (acc),
        .signed_mode (SIGNED_MODE),
        .sum         (sum)
    );

    assign busy = (state != IDLE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            a_reg         <= '0;
            b_reg         <= '0;
            work          <= '0;
            acc           <= '0;
            i             <= '0;
            j             <= '0;
            k             <= '0;
            done          <= 1'b0;
            matrix_result <= '0;
            matrix_count  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg <= matrix_A;
                        b_reg <= matrix_B;
                        acc   <= '0;
                        i     <= '0;
                        j     <= '0;
                        k     <= '0;
                        state <= MAC;
                    end
                end
                MAC: begin
                    if (int'(k) < N - 1) begin
                        acc <= sum;
                        k   <= k + 1'b1;
                    end else begin
                        work[(int'(i) * N + int'(j)) * AW +: AW] <= sum;
                        acc <= '0;
                        k   <= '0;
                        if (int'(j) == N - 1) begin
                            j <= '0;
                            if (int'(i) == N - 1) begin
                                i     <= '0;
                                state <= DONE;
                            end else begin
                                i <= i + 1'b1;
                            end
                        end else begin
                            j <= j + 1'b1;
                        end
                    end
                end
                DONE: begin
                    matrix_result <= work;
                    done          <= 1'b1;
                    matrix_count  <= matrix_count + 1'b1;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_param_matrix_multiplier.sv
// Scoreboard bench for param_matrix_multiplier: a 2x2 instance and a 4x4 instance,
// directed vectors with hand-computed results; honours MATMUL_SIGNED_EN.
module tb_param_matrix_multiplier;

    localparam int AW2 = 9;
    localparam int AW4 = 10;

    logic          clock;
    logic          reset;
    logic          start;
    logic [15:0]   matrix_A;
    logic [15:0]   matrix_B;
    logic          busy;
    logic          done;
    logic [35:0]   matrix_result;
    logic [7:0]    matrix_count;

    logic          start4;
    logic [63:0]   matrix_A4;
    logic [63:0]   matrix_B4;
    logic          busy4;
    logic          done4;
    logic [159:0]  matrix_result4;
    logic [7:0]    matrix_count4;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    logic [35:0]  q_res[$];
    logic [7:0]   q_cnt[$];
    logic [159:0] q_res4[$];
    logic [7:0]   q_cnt4[$];
    logic [7:0]   exp_count;
    logic [7:0]   exp_count4;

    param_matrix_multiplier #(.N(2), .DW(4), .CW(8)) u_dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .matrix_A      (matrix_A),
        .matrix_B      (matrix_B),
        .busy          (busy),
        .done          (done),
        .matrix_result (matrix_result),
        .matrix_count  (matrix_count)
    );

    param_matrix_multiplier #(.N(4), .DW(4), .CW(8)) u_dut4 (
        .clock         (clock),
        .reset         (reset),
        .start         (start4),
        .matrix_A      (matrix_A4),
        .matrix_B      (matrix_B4),
        .busy          (busy4),
        .done          (done4),
        .matrix_result (matrix_result4),
        .matrix_count  (matrix_count4)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] pk_op(input logic [3:0] e00, e01, e10, e11);
        return {e11, e10, e01, e00};
    endfunction

    function automatic logic [35:0] pk_res(input logic [8:0] e00, e01, e10, e11);
        return {e11, e10, e01, e00};
    endfunction

    // Scoreboard monitors
    always @(negedge clock) begin
        if (done) begin
            if (q_res.size() == 0) begin
                check("unexpected_done", 160'(done), 160'(0));
            end else begin
                check("result", 160'(matrix_result), 160'(q_res.pop_front()));
                check("count", 160'(matrix_count), 160'(q_cnt.pop_front()));
            end
        end
    end

    always @(negedge clock) begin
        if (done4) begin
            if (q_res4.size() == 0) begin
                check("unexpected_done4", 160'(done4), 160'(0));
            end else begin
                check("result4", matrix_result4, q_res4.pop_front());
                check("count4", 160'(matrix_count4), 160'(q_cnt4.pop_front()));
            end
        end
    end

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 40) begin
            @(negedge clock);
            n++;
        end
        if (!done) check({name, "_timeout"}, 160'(done), 160'(1));
    endtask

    task automatic run2(input logic [15:0] a, input logic [15:0] b, input logic [35:0] exp);
        @(negedge clock);
        matrix_A = a;
        matrix_B = b;
        start = 1'b1;
        exp_count = exp_count + 8'd1;
        q_res.push_back(exp);
        q_cnt.push_back(exp_count);
        @(negedge clock);
        start = 1'b0;
        wait_done("run2");
    endtask

    task automatic run4(input logic [63:0] a, input logic [63:0] b, input logic [159:0] exp);
        int n = 0;
        @(negedge clock);
        matrix_A4 = a;
        matrix_B4 = b;
        start4 = 1'b1;
        exp_count4 = exp_count4 + 8'd1;
        q_res4.push_back(exp);
        q_cnt4.push_back(exp_count4);
        @(negedge clock);
        start4 = 1'b0;
        while (!done4 && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (!done4) check("run4_timeout", 160'(done4), 160'(1));
    endtask

    logic [15:0]  op_x_a, op_x_b, op_y_a, op_y_b, op_f, op_e, op_id, op_m;
    logic [35:0]  res_x, res_y, res_f, res_m, res_8;
    logic [63:0]  id4, b4, ones4;
    logic [159:0] exp_b4, exp_ones4;

    initial begin
        int n;
        int t1;
        int t2;
        logic hold_bad;

        op_x_a = pk_op(4'd1, 4'd2, 4'd3, 4'd4);
        op_x_b = pk_op(4'd5, 4'd6, 4'd7, 4'd8);
        res_x  = pk_res(9'd19, 9'd22, 9'd43, 9'd50);
        op_y_a = pk_op(4'd1, 4'd1, 4'd1, 4'd1);
        op_y_b = pk_op(4'd3, 4'd5, 4'd7, 4'd9);
        res_y  = pk_res(9'd10, 9'd14, 9'd10, 9'd14);
        op_f   = 16'hFFFF;
        res_f  = pk_res(9'd450, 9'd450, 9'd450, 9'd450);
        op_e   = 16'h8888;
        res_8  = pk_res(9'd128, 9'd128, 9'd128, 9'd128);
        op_id  = pk_op(4'd1, 4'd0, 4'd0, 4'd1);
        op_m   = pk_op(4'hF, 4'd2, 4'd3, 4'hC);
`ifdef MATMUL_SIGNED_EN
        res_m  = pk_res(9'h1FF, 9'd2, 9'd3, 9'h1FC);
`else
        res_m  = pk_res(9'd15, 9'd2, 9'd3, 9'd12);
`endif

        // 4x4 operands: identity, B(r,c) = r*4+c, all-ones
        id4 = '0;
        b4 = '0;
        ones4 = '0;
        exp_b4 = '0;
        exp_ones4 = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                id4[(r*4+c)*4 +: 4] = (r == c) ? 4'd1 : 4'd0;
                b4[(r*4+c)*4 +: 4] = 4'(r*4 + c);
                ones4[(r*4+c)*4 +: 4] = 4'd1;
                exp_ones4[(r*4+c)*AW4 +: AW4] = 10'd4;
`ifdef MATMUL_SIGNED_EN
                exp_b4[(r*4+c)*AW4 +: AW4] = (r*4 + c >= 8) ? 10'(r*4 + c + 1008) : 10'(r*4 + c);
`else
                exp_b4[(r*4+c)*AW4 +: AW4] = 10'(r*4 + c);
`endif
            end
        end

        reset = 1'b0;
        start = 1'b0;
        start4 = 1'b0;
        matrix_A = '0;
        matrix_B = '0;
        matrix_A4 = '0;
        matrix_B4 = '0;
        exp_count = '0;
        exp_count4 = '0;
        repeat (2) @(negedge clock);
        check("rst_busy", 160'(busy), 160'(0));
        check("rst_done", 160'(done), 160'(0));
        check("rst_result", 160'(matrix_result), 160'(0));
        check("rst_count", 160'(matrix_count), 160'(0));
        reset = 1'b1;

        // Basic multiply with busy-length measurement
        @(negedge clock);
        matrix_A = op_x_a;
        matrix_B = op_x_b;
        start = 1'b1;
        exp_count = exp_count + 8'd1;
        q_res.push_back(res_x);
        q_cnt.push_back(exp_count);
        @(negedge clock);
        start = 1'b0;
        n = 0;
        while (busy && n < 50) begin
            n++;
            @(negedge clock);
        end
        check("busy_cycles", 160'(n), 160'(9));
        check("done_after_busy", 160'(done), 160'(1));
        @(negedge clock);
        check("done_one_cycle", 160'(done), 160'(0));

        run2(op_f, op_f, res_f);
        @(negedge clock);
        check("busy_low_after_done", 160'(busy), 160'(0));

        // start held high; operands change mid-run
        @(negedge clock);
        matrix_A = op_x_a;
        matrix_B = op_x_b;
        start = 1'b1;
        q_res.push_back(res_x);
        q_cnt.push_back(exp_count + 8'd1);
        q_res.push_back(res_y);
        q_cnt.push_back(exp_count + 8'd2);
        exp_count = exp_count + 8'd2;
        repeat (3) @(negedge clock);
        matrix_A = op_y_a;
        matrix_B = op_y_b;
        wait_done("held1");
        t1 = cyc;
        hold_bad = 1'b0;
        n = 0;
        do begin
            @(negedge clock);
            n++;
            if (!done && matrix_result !== res_x) hold_bad = 1'b1;
        end while (!done && n < 40);
        t2 = cyc;
        start = 1'b0;
        check("result_hold", 160'(hold_bad), 160'(0));
        check("back_to_back_period", 160'(t2 - t1), 160'(10));

        // Asynchronous reset during the fourth cycle of a multiply
        @(negedge clock);
        matrix_A = op_f;
        matrix_B = op_f;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        check("async_rst_busy", 160'(busy), 160'(0));
        check("async_rst_done", 160'(done), 160'(0));
        check("async_rst_result", 160'(matrix_result), 160'(0));
        check("async_rst_count", 160'(matrix_count), 160'(0));
        @(negedge clock);
        reset = 1'b1;
        exp_count = '0;
        run2(op_x_a, op_x_b, res_x);

        // Counter wrap over 256 multiplies
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        exp_count = '0;
        for (int m = 0; m < 256; m++) begin
            if (m % 2 == 0) run2(op_x_a, op_x_b, res_x);
            else run2(op_f, op_f, res_f);
        end
        @(negedge clock);
        check("count_wrapped", 160'(matrix_count), 160'(0));

        run2(op_e, op_e, res_8);
        run2(op_id, op_m, res_m);

        run4(id4, b4, exp_b4);
        run4(ones4, ones4, exp_ones4);

        repeat (3) @(negedge clock);
        check("sb_empty", 160'(q_res.size()), 160'(0));
        check("sb4_empty", 160'(q_res4.size()), 160'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/param_matrix_multiplier.md
Name: param_matrix_multiplier

Overview:
Parametrised, sequential successor to the fixed 2x2, 4-bit matrix multiplier. It computes C = A x B for square NxN matrices of DW-bit elements using one shared multiply-accumulate (MAC) datapath. Operation is controlled by a start/busy/done handshake. Results are double-buffered and a completed-matrix counter is kept. It sits at top level beside the existing multiplier and reuses its start/count conventions.

Parameters:
N, 2, matrix dimension (rows = cols), legal values 2..8
DW, 4, element width in bits
CW, 8, width of the completed-matrix counter
AW, 2*DW+$clog2(N), derived result-element width (localparam, not overridable)

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
start  input  1  request a multiply; sampled only in IDLE
matrix_A  input  N*N*DW  operand A; element (r,c) at bits [(r*N+c)*DW +: DW]
matrix_B  input  N*N*DW  operand B; same packing as matrix_A
busy  output  1  high while a multiply is in progress
done  output  1  one-cycle pulse when matrix_result updates
matrix_result  output  N*N*AW  C; element (r,c) at bits [(r*N+c)*AW +: AW]
matrix_count  output  CW  number of completed multiplies

Behaviour:
- Reset (reset low, asynchronous): state=IDLE; busy=0, done=0, matrix_result=0, matrix_count=0; operand registers, accumulator and indices cleared. Reset mid-operation aborts the multiply with no partial result and no count increment.
- States: IDLE, MAC, DONE.
- IDLE:
  - If start=1 at a clock edge, capture matrix_A and matrix_B into internal registers.
  - Set i=j=k=0, acc=0, then go to MAC.
  - Operand inputs are don't-care after the capture edge.
- MAC, one product per cycle:
  - p = A[i][k]*B[k][j], unsigned by default; sum = acc + p, computed at AW bits.
  - If k<N-1: acc<=sum, k<=k+1.
  - If k==N-1: write sum into working buffer element (i,j); acc<=0; k<=0; advance j, and on j wrap advance i.
  - After element (N-1,N-1) is written, go to DONE.
- DONE (one cycle):
  - Copy the working buffer to matrix_result.
  - done=1; matrix_count<=matrix_count+1, wrapping from 2^CW-1 to 0.
  - Go to IDLE.
- Latency: start accepted at edge 0. MAC occupies N^3 cycles. done is high in the cycle after edge N^3+1. The earliest next start is accepted one edge later.
- busy=1 in MAC and DONE, 0 in IDLE. start while busy is ignored, not queued.
- matrix_result changes only at the DONE edge; it is never partially updated. It holds its value across subsequent idle time and across the next multiply until that one completes.
- Width rule: AW bits always hold the exact result with no overflow, for both unsigned and signed modes.

Optional Feature:
- Macro: MATMUL_SIGNED_EN.
- When defined: elements are two's-complement; products and accumulation are signed and sign-extended to AW bits; result elements are signed.
- When undefined: all arithmetic is unsigned and zero-extended.
- Ports and timing are identical in both modes.

Decomposition:
- Package matmul_pkg holds:
  - state enum {IDLE, MAC, DONE}
  - a function computing AW from DW and N
  - an index-width helper function
- Natural sub-module: matmul_mac_unit, parametrised on DW and AW. Inputs: a, b, acc_in, signed select. Output: sum. Purely combinational.
- The FSM, index counters, operand registers and buffers stay in param_matrix_multiplier.

Test Plan:
1. N=2, DW=4, A=[1 2;3 4], B=[5 6;7 8], start pulse -> done pulses in the cycle after edge 9; matrix_result=[19 22;43 50]; matrix_count=1; busy high 9 cycles.
2. N=2, DW=4, unsigned, A=B=all 15 -> every element 450 (AW=9, no overflow); busy drops after the done cycle.
3. Hold start high continuously with different operands applied mid-run -> the second operand set is ignored until IDLE. Back-to-back multiplies complete every 10 cycles. matrix_result is unchanged between done pulses.
4. Assert reset at cycle 4 of a multiply -> busy, done, matrix_result and matrix_count read 0 immediately, asynchronously. After release, a new start produces the correct full result.
5. CW=8: run 256 multiplies -> matrix_count wraps 255 -> 0 on the 256th done.
6. MATMUL_SIGNED_EN defined, N=2, DW=4, A=B=all -8 (4'h8) -> every element +128. Also A=identity, B=[-1 2;3 -4] -> result=[-1 2;3 -4]. Repeat case 1 with N=4, A=identity -> result equals B.
